// File: rtl/mem_if_pkg.sv
// Shared types and constants for the accelerator memory responder.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_BEAT = 2'd2,
        WR_BEAT = 2'd3
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int ERR_BUSY  = 0;
    localparam int ERR_RANGE = 1;
    localparam int ERR_COLL  = 2;
    localparam int ERR_BITS  = 3;

endpackage

// File: rtl/mem_responder_ram.sv
// Word-addressed RAM with one prioritised write port, an asynchronous
// accelerator read port and a registered host read port.
module mem_responder_ram #(
    parameter  int DEPTH     = 256,
    parameter  int DATA_BITS = 64,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_accelWe,
    input  logic [AW-1:0]        i_accelAddr,
    input  logic [DATA_BITS-1:0] i_accelData,
    input  logic                 i_hostWe,
    input  logic [AW-1:0]        i_hostAddr,
    input  logic [DATA_BITS-1:0] i_hostData,
    input  logic [AW-1:0]        i_rdAddr,
    output logic [DATA_BITS-1:0] o_rdData,
    output logic [DATA_BITS-1:0] o_hostRdData
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [DATA_BITS-1:0] r_hostRdData;

    // Single write port: an accelerator beat always takes priority over the host.
    always_ff @(posedge clock) begin
        if (i_accelWe) begin
            r_mem[i_accelAddr] <= i_accelData;
        end else if (i_hostWe) begin
            r_mem[i_hostAddr] <= i_hostData;
        end
    end

    // Host read data is refreshed every cycle; contents are never cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hostRdData <= '0;
        end else begin
            r_hostRdData <= r_mem[i_hostAddr];
        end
    end

    assign o_rdData     = r_mem[i_rdAddr];
    assign o_hostRdData = r_hostRdData;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves read/write bursts from a local RAM with a
// programmable read latency, plus a host preload/check port and sticky errors.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter  int MEM_LEN_BITS  = 8,
    parameter  int MEM_ADDR_BITS = 64,
    parameter  int MEM_DATA_BITS = 64,
    parameter  int DEPTH         = 256,
    parameter  int RD_LATENCY    = 2,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_mem_req_valid,
    output logic                     o_mem_req_ready,
    input  logic                     i_mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  i_mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0] i_mem_req_addr,
    input  logic                     i_mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] i_mem_wr_bits,
    output logic                     o_mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0] o_mem_rd_bits,
    input  logic                     i_mem_rd_ready,
    input  logic                     i_host_wr_en,
    input  logic [AW-1:0]            i_host_addr,
    input  logic [MEM_DATA_BITS-1:0] i_host_wr_data,
    output logic [MEM_DATA_BITS-1:0] o_host_rd_data,
    output logic [ERR_BITS-1:0]      o_err,
    input  logic                     i_err_clr
);

    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [MEM_ADDR_BITS-1:0] LIMIT = MEM_ADDR_BITS'(DEPTH);

    state_t                   r_state;
    logic [MEM_ADDR_BITS-1:0] r_curAddr;
    logic [MEM_LEN_BITS-1:0]  r_beatsLeft;
    logic [LW-1:0]            r_latCnt;
    logic                     r_rdValid;
    logic [MEM_DATA_BITS-1:0] r_rdBits;
    logic [ERR_BITS-1:0]      r_err;

    state_t                   w_stateNext;
    logic [MEM_ADDR_BITS-1:0] w_curAddrNext;
    logic [MEM_LEN_BITS-1:0]  w_beatsNext;
    logic [LW-1:0]            w_latNext;
    logic                     w_rdValidNext;
    logic [MEM_DATA_BITS-1:0] w_rdBitsNext;
    logic [ERR_BITS-1:0]      w_errEvent;

    logic                     w_accelBeat;
    logic                     w_accelWe;
    logic                     w_hostWe;
    logic                     w_curInRange;
    logic [MEM_ADDR_BITS-1:0] w_nextAddr;
    logic [MEM_ADDR_BITS-1:0] w_rdAddr;
    logic                     w_rdInRange;
    logic [MEM_DATA_BITS-1:0] w_ramRdData;
    logic [MEM_DATA_BITS-1:0] w_rdLoad;

    assign w_accelBeat  = (r_state == WR_BEAT) && i_mem_wr_valid;
    assign w_curInRange = (r_curAddr < LIMIT);
    assign w_accelWe    = w_accelBeat && w_curInRange;
    assign w_hostWe     = i_host_wr_en && !w_accelBeat;
    assign w_nextAddr   = r_curAddr + MEM_ADDR_BITS'(1);
    // In RD_BEAT the word being fetched is the one after the current beat.
    assign w_rdAddr     = (r_state == RD_BEAT) ? w_nextAddr : r_curAddr;
    assign w_rdInRange  = (w_rdAddr < LIMIT);
    assign w_rdLoad     = w_rdInRange ? w_ramRdData : '0;

    mem_responder_ram #(
        .DEPTH     (DEPTH),
        .DATA_BITS (MEM_DATA_BITS)
    ) u_ram (
        .clock        (clock),
        .reset        (reset),
        .i_accelWe    (w_accelWe),
        .i_accelAddr  (r_curAddr[AW-1:0]),
        .i_accelData  (i_mem_wr_bits),
        .i_hostWe     (w_hostWe),
        .i_hostAddr   (i_host_addr),
        .i_hostData   (i_host_wr_data),
        .i_rdAddr     (w_rdAddr[AW-1:0]),
        .o_rdData     (w_ramRdData),
        .o_hostRdData (o_host_rd_data)
    );

    // Register the FSM state, burst counters, read beat and sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_curAddr   <= '0;
            r_beatsLeft <= '0;
            r_latCnt    <= '0;
            r_rdValid   <= 1'b0;
            r_rdBits    <= '0;
            r_err       <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_curAddr   <= w_curAddrNext;
            r_beatsLeft <= w_beatsNext;
            r_latCnt    <= w_latNext;
            r_rdValid   <= w_rdValidNext;
            r_rdBits    <= w_rdBitsNext;
            r_err       <= (i_err_clr ? '0 : r_err) | w_errEvent;
        end
    end

    // Next-state logic for bursts, read beat loading and error event detection.
    always_comb begin
        w_stateNext   = r_state;
        w_curAddrNext = r_curAddr;
        w_beatsNext   = r_beatsLeft;
        w_latNext     = r_latCnt;
        w_rdValidNext = r_rdValid;
        w_rdBitsNext  = r_rdBits;
        w_errEvent    = '0;

        case (r_state)
            IDLE: begin
                if (i_mem_req_valid) begin
                    w_curAddrNext = i_mem_req_addr;
                    w_beatsNext   = i_mem_req_len;
                    case (i_mem_req_opcode)
                        OP_RD: begin
                            w_stateNext = RD_WAIT;
                            w_latNext   = LW'(RD_LATENCY - 1);
                        end
                        OP_WR: begin
                            w_stateNext = WR_BEAT;
                        end
                    endcase
                end
            end
            RD_WAIT: begin
                if (r_latCnt == '0) begin
                    w_rdBitsNext  = w_rdLoad;
                    w_rdValidNext = 1'b1;
                    w_stateNext   = RD_BEAT;
                    w_errEvent[ERR_RANGE] = !w_rdInRange;
                end else begin
                    w_latNext = r_latCnt - LW'(1);
                end
            end
            RD_BEAT: begin
                if (r_rdValid && i_mem_rd_ready) begin
                    if (r_beatsLeft == '0) begin
                        w_stateNext   = IDLE;
                        w_rdValidNext = 1'b0;
                    end else begin
                        w_curAddrNext = w_nextAddr;
                        w_beatsNext   = r_beatsLeft - MEM_LEN_BITS'(1);
                        w_rdBitsNext  = w_rdLoad;
                        w_errEvent[ERR_RANGE] = !w_rdInRange;
                    end
                end
            end
            WR_BEAT: begin
                if (i_mem_wr_valid) begin
                    w_errEvent[ERR_RANGE] = !w_curInRange;
                    if (r_beatsLeft == '0) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_curAddrNext = w_nextAddr;
                        w_beatsNext   = r_beatsLeft - MEM_LEN_BITS'(1);
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        if (i_mem_req_valid && (r_state != IDLE)) begin
            w_errEvent[ERR_BUSY] = 1'b1;
        end
        if (i_host_wr_en && w_accelBeat) begin
            w_errEvent[ERR_COLL] = 1'b1;
        end
    end

    assign o_mem_req_ready = (r_state == IDLE);
    assign o_mem_rd_valid  = r_rdValid;
    assign o_mem_rd_bits   = r_rdBits;
    assign o_err           = r_err;

endmodule
